// File: rtl/mc_main_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes, state
// encodings, ALU/mux codes and the control word produced by the decoder.
package mc_main_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JR       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // ALU op codes are shared with the ALU controller
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
               (op == OP_ADDI)  || (op == OP_LB) || (op == OP_SB);
    endfunction

    // Unsupported opcodes fall back to FETCH, i.e. execute as a NOP
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
        state_t st;
        case (op)
            OP_LB, OP_SB: st = ST_MEMADR;
            OP_RTYPE:     st = (funct == FUNCT_JR) ? ST_JR : ST_EXECUTE;
            OP_BEQ:       st = ST_BRANCH;
            OP_ADDI:      st = ST_ADDIEXEC;
            OP_J:         st = ST_JUMP;
            default:      st = ST_FETCH;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mc_main_ctrl_outdec.sv
// Combinational state -> control word decoder for the main controller.
// Only FETCH looks at memory ready; every other state is a pure Moore decode.
module mc_main_ctrl_outdec
    import mc_main_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.alusrcb = SRCB_FOUR;
                o_ctrl.irwrite = i_ready;
                o_ctrl.pcwrite = i_ready;
            end
            ST_DECODE: begin
                o_ctrl.alusrcb = SRCB_IMM_SH;
            end
            ST_MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
            end
            ST_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            ST_MEMWR: begin
                // strobe is held for the whole access until memory accepts it
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
            end
            ST_EXECUTE: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.pcsrc   = PCSRC_ALUOUT;
                o_ctrl.branch  = 1'b1;
            end
            ST_ADDIEXEC: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = SRCB_IMM;
            end
            ST_ADDIWB: begin
                o_ctrl.regwrite = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pcsrc   = PCSRC_JUMP;
                o_ctrl.pcwrite = 1'b1;
            end
            ST_JR: begin
                o_ctrl.pcsrc   = PCSRC_REG;
                o_ctrl.pcwrite = 1'b1;
            end
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute,
// producing datapath enables, mux selects and the ALU op code.
module mc_main_ctrl
    import mc_main_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4,
    parameter bit MEM_HS  = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [OP_W-1:0]    funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               iord_o,
    output logic               memwrite_o,
    output logic               irwrite_o,
    output logic               regwrite_o,
    output logic               regdst_o,
    output logic               memtoreg_o,
    output logic               alusrca_o,
    output logic [1:0]         alusrcb_o,
    output logic [1:0]         aluop_o,
    output logic [1:0]         pcsrc_o,
    output logic               pcen_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_ready;

    assign w_ready = MEM_HS ? mem_ready_i : 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:    w_next = w_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:   w_next = decode_next(op_i, funct_i);
            ST_MEMADR:   w_next = (op_i == OP_SB) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    w_next = w_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:    w_next = w_ready ? ST_FETCH : ST_MEMWR;
            ST_EXECUTE:  w_next = ST_ALUWB;
            ST_ADDIEXEC: w_next = ST_ADDIWB;
            default:     w_next = ST_FETCH;
        endcase
    end

    mc_main_ctrl_outdec u_outdec (
        .i_state (r_state),
        .i_ready (w_ready),
        .o_ctrl  (w_ctrl)
    );

    // Reset masks every output combinationally so nothing pending can fire
    always_comb begin
        iord_o     = w_ctrl.iord;
        memwrite_o = w_ctrl.memwrite;
        irwrite_o  = w_ctrl.irwrite;
        regwrite_o = w_ctrl.regwrite;
        regdst_o   = w_ctrl.regdst;
        memtoreg_o = w_ctrl.memtoreg;
        alusrca_o  = w_ctrl.alusrca;
        alusrcb_o  = w_ctrl.alusrcb;
        aluop_o    = w_ctrl.aluop;
        pcsrc_o    = w_ctrl.pcsrc;
        pcen_o     = w_ctrl.pcwrite | (w_ctrl.branch & zero_i);
        illegal_o  = (r_state == ST_DECODE) && !op_supported(op_i);
        state_o    = STATE_W'(r_state);
        if (rst_i) begin
            iord_o     = 1'b0;
            memwrite_o = 1'b0;
            irwrite_o  = 1'b0;
            regwrite_o = 1'b0;
            regdst_o   = 1'b0;
            memtoreg_o = 1'b0;
            alusrca_o  = 1'b0;
            alusrcb_o  = 2'b00;
            aluop_o    = 2'b00;
            pcsrc_o    = 2'b00;
            pcen_o     = 1'b0;
            illegal_o  = 1'b0;
            state_o    = '0;
        end
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed instructions plus a random instruction
// stream, each expanded into its expected per-cycle state/control trace.
module tb_mc_main_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       iord_o, memwrite_o, irwrite_o, regwrite_o, regdst_o, memtoreg_o;
    logic       alusrca_o, pcen_o, illegal_o;
    logic [1:0] alusrcb_o, aluop_o, pcsrc_o;
    logic [3:0] state_o;
    logic [14:0] w_word;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int st;
        bit rdy;
        bit zr;
    } step_t;
    step_t q[$];

    always #5 clk_i = ~clk_i;

    mc_main_ctrl #(.OP_W(6), .STATE_W(4), .MEM_HS(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .op_i        (op_i),
        .funct_i     (funct_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .iord_o      (iord_o),
        .memwrite_o  (memwrite_o),
        .irwrite_o   (irwrite_o),
        .regwrite_o  (regwrite_o),
        .regdst_o    (regdst_o),
        .memtoreg_o  (memtoreg_o),
        .alusrca_o   (alusrca_o),
        .alusrcb_o   (alusrcb_o),
        .aluop_o     (aluop_o),
        .pcsrc_o     (pcsrc_o),
        .pcen_o      (pcen_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o)
    );

    assign w_word = {iord_o, memwrite_o, irwrite_o, regwrite_o, regdst_o, memtoreg_o,
                     alusrca_o, alusrcb_o, aluop_o, pcsrc_o, pcen_o, illegal_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100000, 6'b101000};
    endfunction

    // Expected control word for a state number, straight from the state table
    function automatic logic [14:0] exp_ctrl(input int st, input bit rdy, input bit zr, input bit ill);
        logic iord, mw, irw, rw, rd, m2r, sa, pcen, il;
        logic [1:0] sb, ao, ps;
        {iord, mw, irw, rw, rd, m2r, sa, pcen, il} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            0:  begin sb = 2'b01; irw = rdy; pcen = rdy; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; ao = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pcen = zr; end
            9:  begin sa = 1'b1; sb = 2'b10; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pcen = 1'b1; end
            12: begin ps = 2'b11; pcen = 1'b1; end
            default: ;
        endcase
        return {iord, mw, irw, rw, rd, m2r, sa, sb, ao, ps, pcen, il};
    endfunction

    function automatic void push(input int st, input bit rdy, input bit zr);
        step_t s;
        s.st = st; s.rdy = rdy; s.zr = zr;
        q.push_back(s);
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its cycle-by-cycle expected trace
    task automatic build(input logic [5:0] op, input logic [5:0] funct,
                         input int w_fetch, input int w_mem, input bit zr_br);
        for (int i = 0; i < w_fetch; i++) push(0, 1'b0, rb());
        push(0, 1'b1, rb());
        push(1, rb(), rb());
        if (!legal_op(op)) return;
        case (op)
            6'b100000: begin
                push(2, rb(), rb());
                for (int i = 0; i < w_mem; i++) push(3, 1'b0, rb());
                push(3, 1'b1, rb());
                push(4, rb(), rb());
            end
            6'b101000: begin
                push(2, rb(), rb());
                for (int i = 0; i < w_mem; i++) push(5, 1'b0, rb());
                push(5, 1'b1, rb());
            end
            6'b000000: begin
                if (funct == 6'b001000) push(12, rb(), rb());
                else begin push(6, rb(), rb()); push(7, rb(), rb()); end
            end
            6'b000100: push(8, rb(), zr_br);
            6'b001000: begin push(9, rb(), rb()); push(10, rb(), rb()); end
            6'b000010: push(11, rb(), rb());
            default: ;
        endcase
    endtask

    // Called at posedge+1; drives the step inputs, checks, advances one clock
    task automatic run_steps(input string name);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready_i = s.rdy;
            zero_i      = s.zr;
            #1;
            chk($sformatf("%s_state", name), 32'(state_o), 32'(s.st));
            chk($sformatf("%s_ctrl_st%0d", name, s.st), 32'(w_word),
                32'(exp_ctrl(s.st, s.rdy, s.zr, !legal_op(op_i))));
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                            input int w_fetch, input int w_mem, input bit zr_br);
        op_i    = op;
        funct_i = funct;
        build(op, funct, w_fetch, w_mem, zr_br);
        run_steps(name);
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op, funct;
        ops[0] = 6'b000000; ops[1] = 6'b000010; ops[2] = 6'b000100; ops[3] = 6'b001000;
        ops[4] = 6'b100000; ops[5] = 6'b101000; ops[6] = 6'b111111;

        rst_i = 1'b1; op_i = 6'b000000; funct_i = 6'b100000; zero_i = 1'b0; mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready_i = rb();
            zero_i      = rb();
            #1;
            chk("rst_outputs", 32'(w_word), 32'd0);
            chk("rst_state", 32'(state_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("rel_state", 32'(state_o), 32'd0);
        chk("rel_irwrite", 32'(irwrite_o), 32'd1);
        chk("rel_pcen", 32'(pcen_o), 32'd1);

        do_instr("radd",  6'b000000, 6'b100000, 0, 0, 1'b0);
        do_instr("lbwait", 6'b100000, 6'b000000, 1, 2, 1'b0);
        do_instr("beq_t", 6'b000100, 6'b000000, 0, 0, 1'b1);
        do_instr("beq_nt", 6'b000100, 6'b000000, 0, 0, 1'b0);
        do_instr("jr",    6'b000000, 6'b001000, 0, 0, 1'b0);
        do_instr("j",     6'b000010, 6'b000000, 0, 0, 1'b0);
        do_instr("ill",   6'b111111, 6'b000000, 0, 0, 1'b0);
        do_instr("sb",    6'b101000, 6'b000000, 0, 1, 1'b0);
        do_instr("addi",  6'b001000, 6'b000000, 0, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom);
            funct = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
            do_instr($sformatf("rnd%0d", n), op, funct,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb());
        end

        // Reset while a store is waiting for memory
        op_i = 6'b101000; funct_i = 6'b000000;
        push(0, 1'b1, 1'b0); push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0); push(5, 1'b0, 1'b0);
        run_steps("sbrst");
        mem_ready_i = 1'b0;
        #1;
        chk("sbrst_memwrite_pre", 32'(memwrite_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("sbrst_outputs_in_rst", 32'(w_word), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mem_ready_i = 1'b0;
        #1;
        chk("sbrst_state_after", 32'(state_o), 32'd0);
        chk("sbrst_memwrite_after", 32'(memwrite_o), 32'd0);
        chk("sbrst_irwrite_after", 32'(irwrite_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
